// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory stage: execute->memory and memory->writeback
// bundles, stage FSM states and the memory-width encoding shared with decode.
package memory_access_stage_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_DONE
    } memoryState_;

    typedef struct packed {
        logic        stall;
        logic        flush;
    } control_;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] programCounter;
        logic [31:0] programCounterPlus4;
        logic [4:0]  destinationRegister;
        logic [1:0]  writebackType;
        logic [31:0] result;
        logic [31:0] storeData;
        logic        memoryReadEnable;
        logic        memoryWriteEnable;
        logic [1:0]  memoryWidth;
        logic        memorySigned;
        logic        csrWriteEnable;
        logic [11:0] csrAddress;
        logic [31:0] csrWriteData;
    } executeMemoryPayload_;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] programCounter;
        logic [31:0] programCounterPlus4;
        logic [4:0]  destinationRegister;
        logic [1:0]  writebackType;
        logic [31:0] result;
        logic        csrWriteEnable;
        logic [11:0] csrAddress;
        logic [31:0] csrWriteData;
        logic [31:0] loadData;
        logic        misalignedLoad;
        logic        misalignedStore;
        logic [31:0] faultAddress;
    } memoryWritebackPayload_;

endpackage

// File: rtl/memory_access_stage_aligner.sv
// Byte-lane steering for stores, extraction/extension for loads,
// and misalignment detection.
module load_store_aligner
    import memory_access_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic [31:0] storeSource,
    output logic        misaligned,
    output logic [3:0]  byteEnable,
    output logic [31:0] storeData,
    input  logic [1:0]  loadOffset,
    input  logic [1:0]  loadWidth,
    input  logic        loadSigned,
    input  logic [31:0] loadWord,
    output logic [31:0] loadData
);

    logic [31:0] shifted;

    always_comb begin
        misaligned = 1'b0;
        byteEnable = 4'b1111;
        storeData  = storeSource;
        case (width)
            MEM_BYTE: begin
                byteEnable = 4'b0001 << offset;
                storeData  = {4{storeSource[7:0]}};
            end
            MEM_HALF: begin
                misaligned = offset[0];
                byteEnable = 4'b0011 << offset;
                storeData  = {2{storeSource[15:0]}};
            end
            default: misaligned = (offset != 2'b00);
        endcase
    end

    always_comb begin
        shifted  = loadWord >> {loadOffset, 3'b000};
        loadData = shifted;
        case (loadWidth)
            MEM_BYTE: loadData = {{24{loadSigned & shifted[7]}}, shifted[7:0]};
            MEM_HALF: loadData = {{16{loadSigned & shifted[15]}}, shifted[15:0]};
            default:  loadData = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: drives the req/ack data port, stalls upstream while an
// access is outstanding, and registers the memory->writeback payload.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  executeMemoryPayload_   executeMemoryPayload,
    input  control_                memoryWritebackControl,
    output memoryWritebackPayload_ memoryWritebackPayload,
    output logic                   memoryStallRequest,
    output logic                   dataRequest,
    output logic                   dataWrite,
    output logic [ADDR_WIDTH-1:0]  dataAddress,
    output logic [DATA_WIDTH-1:0]  dataWriteData,
    output logic [3:0]             dataByteEnable,
    input  logic [DATA_WIDTH-1:0]  dataReadData,
    input  logic                   dataAcknowledge,
    output logic                   forwardValid,
    output logic [4:0]             forwardRegister,
    output logic [31:0]            forwardData
);

    memoryState_            state;
    logic                   killed;
    logic [1:0]             accessOffset;
    logic [1:0]             accessWidth;
    logic                   accessSigned;
    logic                   accessRead;
    logic [DATA_WIDTH-1:0]  readBuffer;
    logic                   misaligned;
    logic [3:0]             laneEnable;
    logic [31:0]            laneData;
    logic [31:0]            alignedLoad;
    logic                   memOp;
    logic                   faulting;
    logic                   startAccess;
    logic                   updatePayload;
    memoryWritebackPayload_ nextPayload;

    load_store_aligner aligner (
        .offset      (executeMemoryPayload.result[1:0]),
        .width       (executeMemoryPayload.memoryWidth),
        .storeSource (executeMemoryPayload.storeData),
        .misaligned  (misaligned),
        .byteEnable  (laneEnable),
        .storeData   (laneData),
        .loadOffset  (accessOffset),
        .loadWidth   (accessWidth),
        .loadSigned  (accessSigned),
        .loadWord    (readBuffer),
        .loadData    (alignedLoad)
    );

    assign memOp = executeMemoryPayload.valid && !executeMemoryPayload.illegal
                && (executeMemoryPayload.memoryReadEnable
                    || executeMemoryPayload.memoryWriteEnable);
    assign faulting    = memOp && misaligned;
    assign startAccess = (state == MEM_IDLE) && memOp && !misaligned
                      && !memoryWritebackControl.flush;

    // Gated by reset so an in-flight request vanishes the moment reset rises.
    assign memoryStallRequest = !reset && (startAccess || state == MEM_ACCESS);
    assign dataRequest        = !reset && (state == MEM_ACCESS);

    assign updatePayload = !memoryWritebackControl.stall && !memoryStallRequest
                        && !memoryWritebackControl.flush;

    always_comb begin
        nextPayload                     = '0;
        nextPayload.valid               = executeMemoryPayload.valid;
        nextPayload.illegal             = executeMemoryPayload.illegal || faulting;
        nextPayload.programCounter      = executeMemoryPayload.programCounter;
        nextPayload.programCounterPlus4 = executeMemoryPayload.programCounterPlus4;
        nextPayload.destinationRegister = executeMemoryPayload.destinationRegister;
        nextPayload.writebackType       = executeMemoryPayload.writebackType;
        nextPayload.result              = executeMemoryPayload.result;
        nextPayload.csrWriteEnable      = executeMemoryPayload.csrWriteEnable;
        nextPayload.csrAddress          = executeMemoryPayload.csrAddress;
        nextPayload.csrWriteData        = executeMemoryPayload.csrWriteData;
        nextPayload.misalignedLoad      = faulting && executeMemoryPayload.memoryReadEnable;
        nextPayload.misalignedStore     = faulting && executeMemoryPayload.memoryWriteEnable;
        nextPayload.faultAddress        = faulting ? executeMemoryPayload.result : 32'd0;
        if (state == MEM_DONE && accessRead)
            nextPayload.loadData = alignedLoad;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= MEM_IDLE;
            killed                 <= 1'b0;
            dataWrite              <= 1'b0;
            dataAddress            <= '0;
            dataWriteData          <= '0;
            dataByteEnable         <= 4'b0000;
            readBuffer             <= '0;
            accessOffset           <= 2'b00;
            accessWidth            <= MEM_BYTE;
            accessSigned           <= 1'b0;
            accessRead             <= 1'b0;
            memoryWritebackPayload <= '0;
        end else begin
            if (memoryWritebackControl.flush)
                memoryWritebackPayload.valid <= 1'b0;
            else if (updatePayload)
                memoryWritebackPayload <= nextPayload;

            unique case (state)
                MEM_IDLE: if (startAccess) begin
                    state          <= MEM_ACCESS;
                    dataWrite      <= executeMemoryPayload.memoryWriteEnable;
                    dataAddress    <= {executeMemoryPayload.result[ADDR_WIDTH-1:2], 2'b00};
                    dataWriteData  <= laneData;
                    dataByteEnable <= executeMemoryPayload.memoryWriteEnable
                                      ? laneEnable : 4'b0000;
                    accessOffset   <= executeMemoryPayload.result[1:0];
                    accessWidth    <= executeMemoryPayload.memoryWidth;
                    accessSigned   <= executeMemoryPayload.memorySigned;
                    accessRead     <= executeMemoryPayload.memoryReadEnable;
                end
                MEM_ACCESS: begin
                    // The bus cannot abort; a flush only marks the result dead.
                    if (memoryWritebackControl.flush)
                        killed <= 1'b1;
                    if (dataAcknowledge) begin
                        readBuffer     <= dataReadData;
                        killed         <= 1'b0;
                        dataWrite      <= 1'b0;
                        dataByteEnable <= 4'b0000;
                        state <= (killed || memoryWritebackControl.flush)
                                 ? MEM_IDLE : MEM_DONE;
                    end
                end
                MEM_DONE: if (memoryWritebackControl.flush
                              || !memoryWritebackControl.stall)
                    state <= MEM_IDLE;
                default: state <= MEM_IDLE;
            endcase
        end
    end

    assign forwardValid = executeMemoryPayload.valid
                       && !executeMemoryPayload.memoryReadEnable
                       && executeMemoryPayload.destinationRegister != 5'd0
                       && !executeMemoryPayload.illegal;
    assign forwardRegister = executeMemoryPayload.destinationRegister;
    assign forwardData     = executeMemoryPayload.result;

endmodule
